umi_isolate_drain: RTL and testbench



---
 rtl/umi_isolate_pkg.sv | 17 +
 rtl/umi_isolate_slice.sv | 61 ++++++
 rtl/umi_isolate_drain.sv | 133 +++++++++++++
 tb/tb_umi_isolate_drain.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/umi_isolate_pkg.sv
// rtl/umi_isolate_pkg.sv - shared state type and counter sizing for the UMI isolation stage
package umi_isolate_pkg;

  // Controller states; encoding is visible on the iso_state port
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ISO   = 2'd2,
    ST_WAKE  = 2'd3
  } iso_state_t;

  // Bits needed to count 0..max_count; never narrower than one bit
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/umi_isolate_slice.sv
// rtl/umi_isolate_slice.sv - one-entry UMI register slice with synchronous flush
module umi_isolate_slice #(
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          accept_en,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [CW-1:0] in_cmd,
  input  logic [AW-1:0] in_dstaddr,
  input  logic [AW-1:0] in_srcaddr,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [CW-1:0] out_cmd,
  output logic [AW-1:0] out_dstaddr,
  output logic [AW-1:0] out_srcaddr,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
);

  logic full;
  logic accept;

  // A stalled entry can be replaced in the same cycle it leaves
  assign in_ready  = accept_en & (~full | out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = full;

  // Occupancy: flush wins, then a new beat, then the departing beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (accept) begin
      full <= 1'b1;
    end else if (out_ready) begin
      full <= 1'b0;
    end
  end

  // Payload only loads on accept, so it stays stable while the sink stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_cmd     <= '0;
      out_dstaddr <= '0;
      out_srcaddr <= '0;
      out_data    <= '0;
    end else if (accept) begin
      out_cmd     <= in_cmd;
      out_dstaddr <= in_dstaddr;
      out_srcaddr <= in_srcaddr;
      out_data    <= in_data;
    end
  end

endmodule

// File: rtl/umi_isolate_drain.sv
// rtl/umi_isolate_drain.sv - N-channel UMI isolation stage with drain, clamp and wake window
module umi_isolate_drain
  import umi_isolate_pkg::*;
#(
  parameter int N             = 2,
  parameter int CW            = 32,
  parameter int AW            = 64,
  parameter int DW            = 256,
  parameter int ISO           = 1,
  parameter int WAKE_CYCLES   = 4,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            iso_req,
  output logic            iso_ack,
  output logic [1:0]      iso_state,
  output logic            drop,
  input  logic [N-1:0]    in_valid,
  input  logic [N*CW-1:0] in_cmd,
  input  logic [N*AW-1:0] in_dstaddr,
  input  logic [N*AW-1:0] in_srcaddr,
  input  logic [N*DW-1:0] in_data,
  output logic [N-1:0]    in_ready,
  output logic [N-1:0]    out_valid,
  output logic [N*CW-1:0] out_cmd,
  output logic [N*AW-1:0] out_dstaddr,
  output logic [N*AW-1:0] out_srcaddr,
  output logic [N*DW-1:0] out_data,
  input  logic [N-1:0]    out_ready
);

  localparam int DCW = cnt_width(DRAIN_TIMEOUT);
  localparam int WCW = cnt_width(WAKE_CYCLES);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'((DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0);
  localparam logic [WCW-1:0] WAKE_LAST  = WCW'(WAKE_CYCLES - 1);

  iso_state_t      state, state_n;
  logic [DCW-1:0]  drain_cnt;
  logic [WCW-1:0]  wake_cnt;
  logic            req, accept_en, flush, clamp, all_empty, timeout;
  logic [N-1:0]    s_valid;
  logic [N*CW-1:0] s_cmd;
  logic [N*AW-1:0] s_dstaddr, s_srcaddr;
  logic [N*DW-1:0] s_data;

  // A pure-slice build never sees an isolation request
  assign req       = (ISO != 0) & iso_req;
  assign accept_en = (state == ST_RUN);
  assign clamp     = (state == ST_ISO) | (state == ST_WAKE);
  // Counts a slice whose beat is leaving this cycle as already empty
  assign all_empty = &(~s_valid | out_ready);
  assign timeout   = (DRAIN_TIMEOUT != 0) && (drain_cnt == DRAIN_LAST) && (|s_valid);

  for (genvar i = 0; i < N; i++) begin : g_ch
    umi_isolate_slice #(.CW(CW), .AW(AW), .DW(DW)) u_slice (
      .clk         (clk),
      .reset       (reset),
      .accept_en   (accept_en),
      .flush       (flush),
      .in_valid    (in_valid[i]),
      .in_cmd      (in_cmd[i*CW +: CW]),
      .in_dstaddr  (in_dstaddr[i*AW +: AW]),
      .in_srcaddr  (in_srcaddr[i*AW +: AW]),
      .in_data     (in_data[i*DW +: DW]),
      .in_ready    (in_ready[i]),
      .out_valid   (s_valid[i]),
      .out_cmd     (s_cmd[i*CW +: CW]),
      .out_dstaddr (s_dstaddr[i*AW +: AW]),
      .out_srcaddr (s_srcaddr[i*AW +: AW]),
      .out_data    (s_data[i*DW +: DW]),
      .out_ready   (out_ready[i])
    );
  end

  // Clamp mux is driven only by registered state and slice flops
  assign out_valid   = s_valid & {N{~clamp}};
  assign out_cmd     = clamp ? '0 : s_cmd;
  assign out_dstaddr = clamp ? '0 : s_dstaddr;
  assign out_srcaddr = clamp ? '0 : s_srcaddr;
  assign out_data    = clamp ? '0 : s_data;
  assign iso_ack     = clamp;
  assign iso_state   = state;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_n;
  end

  // Next state; a drain that empties wins over an abort, abort wins over timeout
  always_comb begin
    state_n = state;
    flush   = 1'b0;
    case (state)
      ST_RUN:   if (req) state_n = ST_DRAIN;
      ST_DRAIN: begin
        if (all_empty) begin
          state_n = ST_ISO;
        end else if (!req) begin
          state_n = ST_RUN;
        end else if (timeout) begin
          flush   = 1'b1;
          state_n = ST_ISO;
        end
      end
      ST_ISO:   if (!req) state_n = ST_WAKE;
      ST_WAKE: begin
        if (req)                        state_n = ST_ISO;
        else if (wake_cnt == WAKE_LAST) state_n = ST_RUN;
      end
      default:  state_n = ST_RUN;
    endcase
  end

  // Drain and wake counters run only in their own state and sit at zero otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_cnt <= '0;
      wake_cnt  <= '0;
    end else begin
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DCW'(1) : '0;
      wake_cnt  <= (state == ST_WAKE)  ? wake_cnt + WCW'(1)  : '0;
    end
  end

  // Sticky record that a timeout discarded traffic
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      drop <= 1'b0;
    else if (flush) drop <= 1'b1;
  end

endmodule

// File: tb/tb_umi_isolate_drain.sv
// tb/tb_umi_isolate_drain.sv - self-checking bench for umi_isolate_drain
module tb_umi_isolate_drain;

  localparam int N    = 2;
  localparam int CW   = 32;
  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int PW   = CW + 2*AW + DW;
  localparam int TMO  = 8;
  localparam int WAKE = 4;
  localparam logic [1:0] S_RUN = 2'd0, S_DRAIN = 2'd1, S_ISO = 2'd2, S_WAKE = 2'd3;

  logic clk = 1'b0;
  logic reset;
  logic iso_req, iso_ack, drop;
  logic [1:0] iso_state;
  logic b_iso_req, b_iso_ack, b_drop;
  logic [1:0] b_iso_state;
  logic [N-1:0] in_valid, in_ready, out_valid, out_ready, b_in_ready, b_out_valid;
  logic [N*CW-1:0] in_cmd, out_cmd, b_out_cmd;
  logic [N*AW-1:0] in_dstaddr, out_dstaddr, b_out_dstaddr;
  logic [N*AW-1:0] in_srcaddr, out_srcaddr, b_out_srcaddr;
  logic [N*DW-1:0] in_data, out_data, b_out_data;

  int tests = 0;
  int failed = 0;
  logic [PW-1:0] q[N][$];
  logic [PW-1:0] cur[N];
  int accepted[N];

  always #5 clk = ~clk;

  umi_isolate_drain #(.N(N), .CW(CW), .AW(AW), .DW(DW), .ISO(1),
                      .WAKE_CYCLES(WAKE), .DRAIN_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .iso_req(iso_req), .iso_ack(iso_ack),
    .iso_state(iso_state), .drop(drop),
    .in_valid(in_valid), .in_cmd(in_cmd), .in_dstaddr(in_dstaddr),
    .in_srcaddr(in_srcaddr), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_cmd(out_cmd), .out_dstaddr(out_dstaddr),
    .out_srcaddr(out_srcaddr), .out_data(out_data), .out_ready(out_ready)
  );

  umi_isolate_drain #(.N(N), .CW(CW), .AW(AW), .DW(DW), .ISO(0),
                      .WAKE_CYCLES(WAKE), .DRAIN_TIMEOUT(TMO)) dut_b (
    .clk(clk), .reset(reset), .iso_req(b_iso_req), .iso_ack(b_iso_ack),
    .iso_state(b_iso_state), .drop(b_drop),
    .in_valid(in_valid), .in_cmd(in_cmd), .in_dstaddr(in_dstaddr),
    .in_srcaddr(in_srcaddr), .in_data(in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_cmd(b_out_cmd), .out_dstaddr(b_out_dstaddr),
    .out_srcaddr(b_out_srcaddr), .out_data(b_out_data), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_beat();
    logic [PW-1:0] b;
    for (int k = 0; k < PW; k += 32) b[k +: 32] = $urandom();
    return b;
  endfunction

  task automatic drive_beat(input int i, input logic [PW-1:0] b);
    in_data[i*DW +: DW]    = b[DW-1:0];
    in_srcaddr[i*AW +: AW] = b[DW +: AW];
    in_dstaddr[i*AW +: AW] = b[DW+AW +: AW];
    in_cmd[i*CW +: CW]     = b[DW+2*AW +: CW];
    cur[i] = b;
  endtask

  function automatic logic [PW-1:0] dut_beat(input int i);
    return {out_cmd[i*CW +: CW], out_dstaddr[i*AW +: AW], out_srcaddr[i*AW +: AW], out_data[i*DW +: DW]};
  endfunction

  function automatic logic [PW-1:0] b_beat(input int i);
    return {b_out_cmd[i*CW +: CW], b_out_dstaddr[i*AW +: AW], b_out_srcaddr[i*AW +: AW], b_out_data[i*DW +: DW]};
  endfunction

  // One cycle of free-running traffic against the queue model, both builds checked
  task automatic stream_cycle(input logic [N-1:0] v, input logic [N-1:0] r);
    logic exp_rdy;
    @(negedge clk);
    in_valid  = v;
    out_ready = r;
    for (int i = 0; i < N; i++) drive_beat(i, rand_beat());
    b_iso_req = 1'($urandom_range(0, 1));
    #1;
    check("b_iso_ack", b_iso_ack, 0);
    check("b_iso_state", b_iso_state, S_RUN);
    check("b_drop", b_drop, 0);
    for (int i = 0; i < N; i++) begin
      exp_rdy = (q[i].size() == 0) || r[i];
      check("in_ready", in_ready[i], exp_rdy);
      check("b_in_ready", b_in_ready[i], exp_rdy);
      check("out_valid", out_valid[i], q[i].size() != 0);
      check("b_out_valid", b_out_valid[i], q[i].size() != 0);
      if (q[i].size() != 0) begin
        check("out_payload", dut_beat(i), q[i][0]);
        check("b_out_payload", b_beat(i), q[i][0]);
        if (r[i]) void'(q[i].pop_front());
      end
      if (v[i] && exp_rdy) begin
        q[i].push_back(cur[i]);
        accepted[i]++;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] p;
    int cyc;
    reset = 1'b1; iso_req = 1'b0; b_iso_req = 1'b0;
    in_valid = '0; out_ready = '0;
    in_cmd = '0; in_dstaddr = '0; in_srcaddr = '0; in_data = '0;
    for (int i = 0; i < N; i++) accepted[i] = 0;

    // Reset values
    @(negedge clk); @(negedge clk);
    check("rst_state", iso_state, S_RUN);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", dut_beat(0), 0);
    check("rst_iso_ack", iso_ack, 0);
    check("rst_drop", drop, 0);
    reset = 1'b0;

    // Streaming: ch0 full rate, ch1 random valid and 50% ready
    cyc = 0;
    while (accepted[0] < 100 && cyc < 1000) begin
      stream_cycle({1'($urandom_range(0, 1)), 1'b1}, {1'($urandom_range(0, 1)), 1'b1});
      cyc++;
    end
    check("stream_bound", cyc < 1000, 1);
    check("ch0_one_beat_per_cycle", cyc, 100);
    stream_cycle(2'b00, 2'b11);
    stream_cycle(2'b00, 2'b11);
    b_iso_req = 1'b0;

    // Clean isolate; beat presented as iso_req rises is still taken
    @(negedge clk);
    p = rand_beat(); drive_beat(0, p);
    in_valid = 2'b01; out_ready = 2'b00; iso_req = 1'b1;
    #1 check("rise_state", iso_state, S_RUN);
    check("rise_in_ready", in_ready[0], 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); in_valid = 2'b00;
      #1 check("drain_state", iso_state, S_DRAIN);
      check("drain_in_ready", in_ready, 0);
      check("drain_out_valid", out_valid, 2'b01);
      check("drain_payload", dut_beat(0), p);
    end
    @(negedge clk); out_ready = 2'b11;
    #1 check("drain_release_valid", out_valid, 2'b01);
    check("drain_release_payload", dut_beat(0), p);
    check("drain_iso_ack", iso_ack, 0);
    @(negedge clk);
    #1 check("iso_state", iso_state, S_ISO);
    check("iso_ack", iso_ack, 1);
    check("iso_out_valid", out_valid, 0);
    check("iso_out_data", dut_beat(0), 0);
    check("iso_drop", drop, 0);

    // Wake window: clamps held WAKE cycles despite traffic on the inputs
    @(negedge clk); iso_req = 1'b0; in_valid = 2'b11;
    #1 check("iso_hold", iso_state, S_ISO);
    for (int k = 0; k < WAKE; k++) begin
      @(negedge clk); drive_beat(0, rand_beat()); drive_beat(1, rand_beat());
      #1 check("wake_state", iso_state, S_WAKE);
      check("wake_ack", iso_ack, 1);
      check("wake_out_valid", out_valid, 0);
      check("wake_in_ready", in_ready, 0);
      check("wake_out_data", dut_beat(1), 0);
    end
    @(negedge clk); in_valid = 2'b00;
    #1 check("wake_exit_state", iso_state, S_RUN);
    check("wake_exit_ack", iso_ack, 0);
    check("wake_exit_in_ready", in_ready, 2'b11);

    // Empty drain goes straight to ISO; re-raise during wake returns to ISO
    @(negedge clk); iso_req = 1'b1;
    @(negedge clk);
    #1 check("empty_drain", iso_state, S_DRAIN);
    @(negedge clk); iso_req = 1'b0;
    #1 check("empty_drain_iso", iso_state, S_ISO);
    @(negedge clk);
    #1 check("rewake_w0", iso_state, S_WAKE);
    @(negedge clk);
    #1 check("rewake_w1", iso_state, S_WAKE);
    @(negedge clk); iso_req = 1'b1;
    #1 check("rewake_w2", iso_state, S_WAKE);
    @(negedge clk);
    #1 check("rewake_iso", iso_state, S_ISO);
    check("rewake_ack", iso_ack, 1);
    @(negedge clk); iso_req = 1'b0;
    repeat (WAKE + 1) @(negedge clk);
    #1 check("rewake_run", iso_state, S_RUN);

    // Drain timeout: ch1 stuck full, ISO exactly TMO cycles after DRAIN entry
    @(negedge clk);
    p = rand_beat(); drive_beat(1, p); in_valid = 2'b10; out_ready = 2'b00;
    @(negedge clk); in_valid = 2'b00; iso_req = 1'b1;
    #1 check("tmo_loaded", out_valid, 2'b10);
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      #1 check("tmo_drain_state", iso_state, S_DRAIN);
      check("tmo_drain_drop", drop, 0);
      check("tmo_drain_valid", out_valid, 2'b10);
    end
    @(negedge clk);
    #1 check("tmo_iso_state", iso_state, S_ISO);
    check("tmo_drop", drop, 1);
    check("tmo_out_valid", out_valid, 0);
    @(negedge clk); out_ready = 2'b11; iso_req = 1'b0;
    for (int k = 0; k <= WAKE; k++) begin
      @(negedge clk);
      #1 check("tmo_beat_gone", out_valid, 0);
    end
    check("tmo_run", iso_state, S_RUN);
    check("tmo_drop_sticky", drop, 1);

    // Abort drain: two-cycle pulse with ch0 stalled, beat survives
    @(negedge clk);
    p = rand_beat(); drive_beat(0, p); in_valid = 2'b01; out_ready = 2'b00;
    @(negedge clk); in_valid = 2'b00; iso_req = 1'b1;
    #1 check("abort_a0_ack", iso_ack, 0);
    @(negedge clk);
    #1 check("abort_a1_state", iso_state, S_DRAIN);
    check("abort_a1_ack", iso_ack, 0);
    @(negedge clk); iso_req = 1'b0;
    #1 check("abort_a2_state", iso_state, S_DRAIN);
    check("abort_a2_ack", iso_ack, 0);
    @(negedge clk);
    #1 check("abort_run", iso_state, S_RUN);
    check("abort_ack", iso_ack, 0);
    check("abort_valid", out_valid, 2'b01);
    @(negedge clk); out_ready = 2'b01;
    #1 check("abort_deliver_valid", out_valid, 2'b01);
    check("abort_deliver_payload", dut_beat(0), p);
    check("abort_drop_sticky", drop, 1);
    @(negedge clk); out_ready = 2'b00;
    #1 check("abort_once", out_valid, 0);

    // Asynchronous reset mid-DRAIN, then re-entry while iso_req stays high
    @(negedge clk);
    drive_beat(0, rand_beat()); in_valid = 2'b01; out_ready = 2'b00;
    @(negedge clk); in_valid = 2'b00; iso_req = 1'b1;
    @(negedge clk);
    #1 check("rst_mid_drain", iso_state, S_DRAIN);
    check("rst_mid_valid_before", out_valid, 2'b01);
    #1 reset = 1'b1;
    #1 check("async_rst_valid", out_valid, 0);
    check("async_rst_state", iso_state, S_RUN);
    check("async_rst_drop", drop, 0);
    check("async_rst_data", dut_beat(0), 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    #1 check("reenter_drain", iso_state, S_DRAIN);
    @(negedge clk);
    #1 check("reenter_iso", iso_state, S_ISO);
    check("reenter_ack", iso_ack, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
